// File: rtl/int_muldiv_pkg.sv
// Shared encodings and constants for the RV32M multiply/divide sequencer.
package int_muldiv_pkg;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREP,
    ST_ITER,
    ST_FIX,
    ST_DONE
  } state_t;

  localparam logic [4:0]  CNT_RELOAD    = 5'd31;
  localparam logic [31:0] DIV_ZERO_QUOT = 32'hFFFF_FFFF;
  localparam logic [31:0] DIV_OVF_QUOT  = 32'h8000_0000;

endpackage

// File: rtl/int_muldiv_dp.sv
// Datapath for the multiply/divide sequencer: 64-bit accumulator, shared
// 33-bit adder/subtractor, one-bit shifter and the sign-fixup negators.
// Optional INT_MULDIV_FAST_MUL_EN adds a single-cycle 33x33 signed multiplier.
module int_muldiv_dp
  import int_muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        step,
  input  logic        div_mode,
  input  logic [31:0] mag_a,
  input  logic [31:0] mag_b,
`ifdef INT_MULDIV_FAST_MUL_EN
  input  logic [32:0] fast_a,
  input  logic [32:0] fast_b,
`endif
  input  logic        neg_prod,
  input  logic        neg_quot,
  input  logic        neg_rem,
  output logic [63:0] product,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  logic [63:0] acc_q, acc_d;
  logic [31:0] operand_q;
  logic [32:0] add_a, add_b, add_sum;

`ifdef INT_MULDIV_FAST_MUL_EN
  logic signed [65:0] fast_prod;
  assign fast_prod = $signed(fast_a) * $signed(fast_b);
`endif

  // One iteration step: shift-add for multiply, restoring trial-subtract for divide
  always_comb begin
    add_a   = div_mode ? acc_q[63:31] : {1'b0, acc_q[63:32]};
    add_b   = {1'b0, operand_q};
    add_sum = add_a + (div_mode ? ~add_b : add_b) + {32'd0, div_mode};
    if (div_mode) begin
      acc_d = add_sum[32] ? {acc_q[62:31], acc_q[30:0], 1'b0}
                          : {add_sum[31:0], acc_q[30:0], 1'b1};
    end else begin
      acc_d = acc_q[0] ? {add_sum, acc_q[31:1]} : {1'b0, acc_q[63:1]};
    end
  end

  // Accumulator and fixed operand (multiplicand or divisor) registers
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q     <= 64'd0;
      operand_q <= 32'd0;
    end else if (load) begin
`ifdef INT_MULDIV_FAST_MUL_EN
      if (!div_mode) begin
        acc_q     <= fast_prod[63:0];
        operand_q <= mag_a;
      end else
`endif
      begin
        acc_q     <= div_mode ? {32'd0, mag_a} : {32'd0, mag_b};
        operand_q <= div_mode ? mag_b : mag_a;
      end
    end else if (step) begin
      acc_q <= acc_d;
    end
  end

  // Sign fixup: quotient sits in the low half, remainder in the high half
  always_comb begin
    product   = neg_prod ? (64'd0 - acc_q) : acc_q;
    quotient  = neg_quot ? (32'd0 - acc_q[31:0]) : acc_q[31:0];
    remainder = neg_rem  ? (32'd0 - acc_q[63:32]) : acc_q[63:32];
  end

endmodule

// File: rtl/int_muldiv_seq.sv
// RV32M multi-cycle multiply/divide sequencer: FSM, iteration counter,
// special-case detection and result register.
// Optional INT_MULDIV_FAST_MUL_EN: multiplies complete via PREP->FIX->DONE.
module int_muldiv_seq
  import int_muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  func3,
  input  logic [31:0] op1,
  input  logic [31:0] op2,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  state_t      state_q, state_d;
  logic [31:0] op1_q, op2_q;
  logic [2:0]  func3_q;
  logic [4:0]  cnt_q;
  logic [31:0] result_q, result_d;
  logic        take_op, result_en, dp_load, dp_step;

  logic        is_div, signed1, signed2, sign1, sign2, div_zero, div_ovf;
  logic [31:0] mag1, mag2, special_val, fix_val;
  logic        neg_prod;
  logic [63:0] product;
  logic [31:0] quotient, remainder;

  // Operand signedness, magnitudes, special cases and output selection
  always_comb begin
    is_div   = func3_q[2];
    signed1  = (func3_q == F3_MULH) || (func3_q == F3_MULHSU) ||
               (func3_q == F3_DIV)  || (func3_q == F3_REM);
    signed2  = (func3_q == F3_MULH) || (func3_q == F3_DIV) || (func3_q == F3_REM);
    sign1    = signed1 & op1_q[31];
    sign2    = signed2 & op2_q[31];
    mag1     = sign1 ? (32'd0 - op1_q) : op1_q;
    mag2     = sign2 ? (32'd0 - op2_q) : op2_q;
    div_zero = is_div && (op2_q == 32'd0);
    div_ovf  = ((func3_q == F3_DIV) || (func3_q == F3_REM)) &&
               (op1_q == DIV_OVF_QUOT) && (op2_q == DIV_ZERO_QUOT);
    if (div_zero) begin
      special_val = func3_q[1] ? op1_q : DIV_ZERO_QUOT;
    end else begin
      special_val = func3_q[1] ? 32'd0 : DIV_OVF_QUOT;
    end
    case (func3_q)
      F3_MUL:                        fix_val = product[31:0];
      F3_MULH, F3_MULHSU, F3_MULHU:  fix_val = product[63:32];
      F3_DIV, F3_DIVU:               fix_val = quotient;
      default:                       fix_val = remainder;
    endcase
`ifdef INT_MULDIV_FAST_MUL_EN
    neg_prod = 1'b0;
`else
    neg_prod = sign1 ^ sign2;
`endif
  end

  int_muldiv_dp u_dp (
    .clk       (clk),
    .reset     (reset),
    .load      (dp_load),
    .step      (dp_step),
    .div_mode  (is_div),
    .mag_a     (mag1),
    .mag_b     (mag2),
`ifdef INT_MULDIV_FAST_MUL_EN
    .fast_a    ({sign1, op1_q}),
    .fast_b    ({sign2, op2_q}),
`endif
    .neg_prod  (neg_prod),
    .neg_quot  (sign1 ^ sign2),
    .neg_rem   (sign1),
    .product   (product),
    .quotient  (quotient),
    .remainder (remainder)
  );

  // Next-state and control decode; flush overrides everything
  always_comb begin
    state_d   = state_q;
    take_op   = 1'b0;
    dp_load   = 1'b0;
    dp_step   = 1'b0;
    result_en = 1'b0;
    result_d  = result_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          take_op = 1'b1;
          state_d = ST_PREP;
        end
      end
      ST_PREP: begin
        dp_load = 1'b1;
        if (div_zero || div_ovf) begin
          result_en = 1'b1;
          result_d  = special_val;
          state_d   = ST_DONE;
        end
`ifdef INT_MULDIV_FAST_MUL_EN
        else if (!is_div) begin
          state_d = ST_FIX;
        end
`endif
        else begin
          state_d = ST_ITER;
        end
      end
      ST_ITER: begin
        dp_step = 1'b1;
        if (cnt_q == 5'd0) state_d = ST_FIX;
      end
      ST_FIX: begin
        result_en = 1'b1;
        result_d  = fix_val;
        state_d   = ST_DONE;
      end
      ST_DONE: begin
        if (start) begin
          take_op = 1'b1;
          state_d = ST_PREP;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (flush) begin
      state_d   = ST_IDLE;
      take_op   = 1'b0;
      dp_load   = 1'b0;
      dp_step   = 1'b0;
      result_en = 1'b0;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Capture the request so later input changes cannot disturb the operation
  always_ff @(posedge clk) begin
    if (reset) begin
      op1_q   <= 32'd0;
      op2_q   <= 32'd0;
      func3_q <= 3'd0;
    end else if (take_op) begin
      op1_q   <= op1;
      op2_q   <= op2;
      func3_q <= func3;
    end
  end

  // Iteration counter: 31 down to 0 gives 32 steps
  always_ff @(posedge clk) begin
    if (reset)        cnt_q <= 5'd0;
    else if (dp_load) cnt_q <= CNT_RELOAD;
    else if (dp_step) cnt_q <= cnt_q - 5'd1;
  end

  // Result register, held until the next completed operation
  always_ff @(posedge clk) begin
    if (reset)          result_q <= 32'd0;
    else if (result_en) result_q <= result_d;
  end

  assign busy   = (state_q == ST_PREP) || (state_q == ST_ITER) || (state_q == ST_FIX);
  assign done   = (state_q == ST_DONE);
  assign result = result_q;

endmodule

// File: tb/tb_int_muldiv_seq.sv
// Scoreboard testbench for int_muldiv_seq: directed vectors with
// hand-computed results and DONE cycles; a monitor checks every DONE.
module tb_int_muldiv_seq;

  localparam logic [2:0] MUL = 3'b000, MULH = 3'b001, MULHSU = 3'b010, MULHU = 3'b011;
  localparam logic [2:0] DIV = 3'b100, DIVU = 3'b101, REM = 3'b110, REMU = 3'b111;
`ifdef INT_MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 3;
`else
  localparam int MUL_LAT = 35;
`endif
  localparam int DIV_LAT = 35;
  localparam int SPC_LAT = 2;

  logic        clk, reset, start, flush;
  logic [2:0]  func3;
  logic [31:0] op1, op2;
  logic        busy, done;
  logic [31:0] result;

  typedef struct {
    logic [31:0] value;
    int          cycle;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  bit   overlap_seen = 1'b0;

  int_muldiv_seq dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .func3  (func3),
    .op1    (op1),
    .op2    (op2),
    .flush  (flush),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle index: inputs driven while cyc==N are sampled at edge eN
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pop and compare on every DONE pulse
  always @(negedge clk) begin
    exp_t e;
    if (busy === 1'b1 && done === 1'b1) overlap_seen = 1'b1;
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("[TB] FAIL unexpected_done: DONE at cycle %0d with nothing pending, result %h", cyc, result);
      end else begin
        e = sb.pop_front();
        tests++;
        if (result !== e.value) begin
          fails++;
          $display("[TB] FAIL %s result: got %h expected %h", e.name, result, e.value);
        end
        tests++;
        if (cyc != e.cycle) begin
          fails++;
          $display("[TB] FAIL %s done_cycle: got %0d expected %0d", e.name, cyc, e.cycle);
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Wait (bounded) for DONE, checking BUSY is high exactly in offsets 1..lat-1
  task automatic waitDone(input string name, input int issue, input int lat);
    int   n = 0;
    int   off;
    bit   busy_ok = 1'b1;
    int   bad_off = 0;
    logic bad_val = 1'b0;
    while (done !== 1'b1 && n < lat + 10) begin
      off = cyc - issue;
      if (busy_ok && busy !== ((off >= 1) && (off < lat))) begin
        busy_ok = 1'b0;
        bad_off = off;
        bad_val = busy;
      end
      @(negedge clk);
      n++;
    end
    tests++;
    if (!busy_ok) begin
      fails++;
      $display("[TB] FAIL %s busy_profile: busy=%b at offset %0d, required %b", name, bad_val, bad_off, ~bad_val);
    end
    tests++;
    if (done !== 1'b1) begin
      fails++;
      $display("[TB] FAIL %s timeout: done=%b after %0d cycles, required 1", name, done, n);
    end
  endtask

  // Issue one operation at the current negedge and wait for its DONE;
  // returns in the DONE cycle so the next call issues back-to-back.
  task automatic applyStimulus(input string name, input logic [2:0] f, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] expv, input int lat);
    int issue;
    start = 1'b1;
    func3 = f;
    op1   = a;
    op2   = b;
    issue = cyc;
    sb.push_back('{value: expv, cycle: cyc + lat, name: name});
    @(negedge clk);
    start = 1'b0;
    op1   = $urandom;
    op2   = $urandom;
    func3 = 3'($urandom_range(7));
    waitDone(name, issue, lat);
  endtask

  initial begin
    int issue;
    reset = 1'b1;
    start = 1'b0;
    flush = 1'b0;
    func3 = 3'd0;
    op1   = 32'd0;
    op2   = 32'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("reset_done", {31'd0, done}, 32'd0);
    checkOutput("reset_result", result, 32'd0);

    // Multiplies, issued back-to-back in each DONE cycle
    applyStimulus("mul", MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT);
    applyStimulus("mulhu", MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT);
    applyStimulus("mulh", MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, MUL_LAT);
    applyStimulus("mulhsu", MULHSU, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, MUL_LAT);
    repeat (3) @(negedge clk);

    // Divides and remainders
    applyStimulus("div_neg", DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, DIV_LAT);
    applyStimulus("rem_neg", REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, DIV_LAT);
    applyStimulus("divu", DIVU, 32'd100, 32'd7, 32'd14, DIV_LAT);
    applyStimulus("remu", REMU, 32'd100, 32'd7, 32'd2, DIV_LAT);
    repeat (2) @(negedge clk);

    // Short-path special cases
    applyStimulus("divu_by0", DIVU, 32'd100, 32'd0, 32'hFFFF_FFFF, SPC_LAT);
    applyStimulus("remu_by0", REMU, 32'd100, 32'd0, 32'h0000_0064, SPC_LAT);
    applyStimulus("div_ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, SPC_LAT);
    applyStimulus("rem_ovf", REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, SPC_LAT);
    repeat (2) @(negedge clk);

    // Flush in cycle 10 of a DIVU, with START held high during BUSY
    start = 1'b1;
    func3 = DIVU;
    op1   = 32'd1000;
    op2   = 32'd3;
    issue = cyc;
    @(negedge clk);
    func3 = DIV;
    op1   = 32'd5;
    op2   = 32'd1;
    while (cyc - issue < 10) @(negedge clk);
    start = 1'b0;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checkOutput("flush_busy_low", {31'd0, busy}, 32'd0);
    checkOutput("flush_result_held", result, 32'h0000_0000);
    @(negedge clk);
    applyStimulus("divu_after_flush", DIVU, 32'd1000, 32'd3, 32'd333, DIV_LAT);

    // START held through BUSY with changing operands must not restart
    start = 1'b1;
    func3 = DIVU;
    op1   = 32'd100;
    op2   = 32'd7;
    issue = cyc;
    sb.push_back('{value: 32'd14, cycle: cyc + DIV_LAT, name: "start_held"});
    repeat (30) begin
      @(negedge clk);
      op1 = $urandom;
      op2 = $urandom;
    end
    start = 1'b0;
    waitDone("start_held", issue, DIV_LAT);

    // FLUSH together with START in the DONE cycle drops the request
    start = 1'b1;
    flush = 1'b1;
    func3 = REMU;
    op1   = 32'd9;
    op2   = 32'd4;
    @(negedge clk);
    start = 1'b0;
    flush = 1'b0;
    checkOutput("flush_start_busy", {31'd0, busy}, 32'd0);
    repeat (5) @(negedge clk);
    checkOutput("flush_start_result", result, 32'd14);

    // Reset mid-operation returns outputs to reset values
    applyStimulus("divu_pre_reset", DIVU, 32'd50, 32'd5, 32'd10, DIV_LAT);
    start = 1'b1;
    func3 = DIVU;
    op1   = 32'd77;
    op2   = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("midreset_busy", {31'd0, busy}, 32'd0);
    checkOutput("midreset_result", result, 32'd0);
    repeat (40) @(negedge clk);

    tests++;
    if (overlap_seen) begin
      fails++;
      $display("[TB] FAIL busy_done_overlap: seen=%b required 0", overlap_seen);
    end
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("[TB] FAIL pending_ops: %0d left required 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/int_muldiv_seq.md
# int_muldiv_seq

Multi-cycle sequencer for the RV32M multiply/divide instructions in the execute stage, beside the integer ALU. It accepts one operation at a time from decode, runs it iteratively over 32 cycles (shift-add multiply, restoring divide), and holds the pipeline through BUSY until a one-cycle DONE pulse presents RESULT. Divide-by-zero and signed overflow take a short path that bypasses the iteration.

## Interface
- No parameters; data width fixed at 32.
- CLK  input  1  single clock, rising edge.
- RESET  input  1  synchronous, active-high.
- START  input  1  request; sampled only in IDLE or DONE state.
- FUNC3  input  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- OP1  input  32  rs1 value; multiplicand or dividend.
- OP2  input  32  rs2 value; multiplier or divisor.
- FLUSH  input  1  abort the operation in flight; no DONE is produced.
- BUSY  output  1  operation in flight; the pipeline stalls while high.
- DONE  output  1  one-cycle pulse; RESULT valid in the same cycle.
- RESULT  output  32  final value; held until the next DONE.

## Operation
- States: IDLE, PREP, ITER, FIX, DONE.
- IDLE/DONE + START: latch OP1, OP2 and FUNC3 into internal registers, then go to PREP. Later input changes are ignored.
- PREP:
  - Compute operand signs and magnitudes.
    - MULH, DIV, REM: both operands signed.
    - MULHSU: OP1 signed, OP2 unsigned.
    - MULHU, DIVU, REMU: both unsigned.
    - MUL: the low word is sign-agnostic, so operands are treated as unsigned.
  - Clear the 64-bit accumulator/remainder and load the 5-bit counter with 31.
  - Special cases go straight to DONE:
    - Divisor 0: DIV/DIVU give 0xFFFFFFFF; REM/REMU give OP1.
    - DIV 0x80000000 / 0xFFFFFFFF gives 0x80000000; the matching REM gives 0.
  - All other operations go to ITER.
- ITER: one step per cycle.
  - Multiply: if multiplier bit 0 is set, add the multiplicand into the upper accumulator half, then shift right 1.
  - Divide: shift left 1, trial-subtract the divisor, and restore on borrow; the quotient bit enters the LSB.
  - Counter decrements; at 0, go to FIX.
- FIX:
  - Multiply: negate the 64-bit product if operand signs differ.
  - Divide: negate the quotient if signs differ; the remainder takes the dividend's sign.
  - Select the output: MUL takes the low 32 bits; MULH/MULHSU/MULHU take the high 32; DIV/DIVU take the quotient; REM/REMU take the remainder. Register the selection into RESULT, then go to DONE.
- DONE: DONE=1 and BUSY=0. Without START go to IDLE; with START go to PREP (back-to-back accepted).
- START while BUSY is ignored and not queued.
- FLUSH in any state: go to IDLE next cycle. DONE stays low and RESULT is unchanged.
- FLUSH together with START: FLUSH wins and the request is dropped.
- RESET mid-operation: same as FLUSH, and outputs return to their reset values.
- Arithmetic:
  - All magnitudes are 32-bit unsigned; |0x80000000| is 0x80000000.
  - The accumulator is 64 bits; the divide trial difference is 33 bits, and bit 32 is the borrow.

## Timing
- Reset values: BUSY=0, DONE=0, RESULT=0x00000000. The FSM resets to IDLE.
- START high in cycle 0 (edge e0): PREP in cycle 1, ITER in cycles 2–33, FIX in cycle 34, DONE=1 in cycle 35.
- BUSY is high in cycles 1–34.
- Special case: PREP in cycle 1, DONE=1 in cycle 2.
- Issue rate: a START in the DONE cycle gives the next DONE 35 cycles later.
- BUSY and DONE are never high together.

## Configuration
- INT_MULDIV_FAST_MUL_EN: all four multiply ops use a single-cycle 33x33 signed multiplier in PREP.
  - Multiplies then go PREP→FIX→DONE, with DONE in cycle 3.
  - Divide ops are unchanged.
- Without the macro, multiplies use the 32-cycle shift-add path, with DONE in cycle 35.

## Structure
- Package int_muldiv_pkg holds:
  - FUNC3 localparams.
  - The FSM state enum.
  - Counter reload constant 31.
  - Special-case result constants 0xFFFFFFFF and 0x80000000.
- Sub-module int_muldiv_dp holds the accumulator, shifter, 33-bit adder/subtractor and negators, driven by FSM step and mode controls.
- The FSM, counter, special-case detection and RESULT register live in the top level.

## Test plan
- MUL 7 × 0xFFFFFFFD: RESULT 0xFFFFFFEB, DONE in cycle 35, BUSY high in cycles 1–34.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF gives 0xFFFFFFFE; MULH on the same operands gives 0x00000000; MULHSU 0xFFFFFFFF × 0x00000002 gives 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 gives 0xFFFFFFFD; REM gives 0xFFFFFFFF; DIVU 100 / 7 gives 14; REMU gives 2.
- DIVU 100 / 0 gives 0xFFFFFFFF and REMU gives 0x64, both with DONE in cycle 2. DIV 0x80000000 / 0xFFFFFFFF gives 0x80000000 and REM gives 0, also with DONE in cycle 2.
- FLUSH in cycle 10 of a DIVU:
  - BUSY goes low in cycle 11, no DONE occurs, and RESULT is unchanged.
  - START in cycle 12 is accepted, giving DONE in cycle 47.
  - START held high during BUSY does not restart the operation.
- Back-to-back: START in the DONE cycle yields a second DONE 35 cycles later. Under INT_MULDIV_FAST_MUL_EN, MUL 7 × 0xFFFFFFFD gives DONE in cycle 3 with 0xFFFFFFEB.
